// File: rtl/add_serial_16.sv
// add_serial_16 -- nibble-serial adder around one 4-bit ripple-carry slice.
//
// Takes a WIDTH-bit operand pair over a valid/ready handshake. It runs the
// pair through a single 4-bit slice, one nibble per clock and LSB nibble
// first, with the carry held in a register between nibbles. The sum is built
// up in a right-shifting register and returned over a second valid/ready
// handshake. This uses a lot less logic than a full-width ripple chain, at
// the cost of WIDTH/4 cycles of latency.
//
// Parameters:
//   WIDTH      operand/sum width, a multiple of 4 and >= 4 (default 16)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   block can accept operands (IDLE)
//   a, b       operands
//   c_in       carry into nibble 0
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   sum        registered sum
//   c_out      carry out of the top nibble
//   ovf        signed overflow, exists only when ADD_SER_OVF_EN is defined
//
// Optional feature macro: ADD_SER_OVF_EN (adds the ovf port and its state).

// One 4-bit ripple-carry slice. It is built from per-bit full adders.
module add4_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [4:0] w_c;
  assign w_c[0] = i_c;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_c = w_c[4];
endmodule

module add_serial_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef ADD_SER_OVF_EN
  output logic             c_out,
  output logic             ovf
`else
  output logic             c_out
`endif
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("add_serial_16: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout;
  logic             w_load, w_step, w_last;
  logic [3:0]       w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_nxt;

  add4_slice u_slice (
    .i_a (r_a[3:0]),
    .i_b (r_b[3:0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_co)
  );

  // Each new slice result enters at the top of the sum register. After N
  // steps, nibble 0 has been shifted down to the bottom.
  assign w_sum_nxt = (r_sum >> 4) | (WIDTH'(w_s) << (WIDTH - 4));
  assign w_last    = (r_cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake outputs. The outputs are decoded from state only.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= c_in;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      r_carry <= w_co;
      r_sum   <= w_sum_nxt;
      r_cnt   <= r_cnt + CW'(1);
      // c_out is captured separately so that it stays at the last result
      // while the running carry register is reloaded for the next operation.
      if (w_last) r_cout <= w_co;
    end
  end

  assign sum   = r_sum;
  assign c_out = r_cout;

`ifdef ADD_SER_OVF_EN
  logic r_amsb, r_bmsb, r_ovf;

  // The operand sign bits are captured at load time because the shift
  // registers lose them. On the last step, w_s[3] is the sum sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_load) begin
      r_amsb <= a[WIDTH-1];
      r_bmsb <= b[WIDTH-1];
    end else if (w_step && w_last) begin
      r_ovf  <= (r_amsb == r_bmsb) && (w_s[3] != r_amsb);
    end
  end

  assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_add_serial_16.sv
module tb_add_serial_16;
  logic        clk, rst_n, in_valid, in_ready, c_in, out_valid, out_ready, c_out;
  logic [15:0] a, b, sum;
  logic        ovf;
  int          checks = 0, failures = 0;

  add_serial_16 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum),
`ifdef ADD_SER_OVF_EN
    .c_out(c_out), .ovf(ovf)
`else
    .c_out(c_out)
`endif
  );

`ifndef ADD_SER_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        ci;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ovf(input string nm, input logic exp);
`ifdef ADD_SER_OVF_EN
    chk(nm, ovf, exp);
`endif
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One complete operation. Entry and exit are both #1 after a rising edge.
  task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                       input logic [15:0] es, input logic ec, input logic eo,
                       input int gap, input int hold, input bit chk_lat, input string nm);
    int n;
    repeat (gap) tick();
    in_valid = 1'b1; a = ai; b = bi; c_in = ci;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({nm, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    out_ready = (hold == 0);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk({nm, "_out_valid"}, out_valid, 1'b1);
    if (chk_lat) chk({nm, "_latency"}, n, 4);
    repeat (hold) tick();
    out_ready = 1'b1;
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, c_out, ec);
    chk_ovf({nm, "_ovf"}, eo);
    tick();
    if (chk_lat) chk({nm, "_idle_after"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [16:0] ref_v;
    logic [15:0] ra, rb;
    logic        rc;
    logic [15:0] ba[3], bb[3];
    logic        bc[3];
    int          t[3], k, r, cyc;
    bit          acc;

    vt[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[5]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[6]  = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[7]  = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vt[8]  = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vt[9]  = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[10] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 16'h0);
    chk("rst_cout", c_out, 1'b0);
    chk_ovf("rst_ovf", 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++)
      do_op(vt[i].a, vt[i].b, vt[i].ci, vt[i].s, vt[i].co, vt[i].ov, 0, 0, 1'b1,
            $sformatf("vec%0d", i));

    // Reset after two RUN cycles
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; c_in = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_sum", sum, 16'h0);
    chk("midrst_cout", c_out, 1'b0);
    chk_ovf("midrst_ovf", 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 0, 1'b1, "after_rst");

    // Backpressure: hold DONE and try to push a second operation during the hold
    in_valid = 1'b1; a = 16'h8000; b = 16'h8000; c_in = 1'b0; out_ready = 1'b0;
    tick();
    a = 16'h1111; b = 16'h2222;
    repeat (4) tick();
    chk("bp_valid_rise", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("bp_hold%0d_in_ready", i), in_ready, 1'b0);
      chk($sformatf("bp_hold%0d_sum", i), sum, 16'h0000);
      chk($sformatf("bp_hold%0d_cout", i), c_out, 1'b1);
      chk_ovf($sformatf("bp_hold%0d_ovf", i), 1'b1);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_release_idle", in_ready, 1'b1);
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_keep_sum", sum, 16'h0000);
    chk("bp_keep_cout", c_out, 1'b1);
    repeat (6) tick();
    chk("bp_not_queued", out_valid, 1'b0);

    // Back-to-back with in_valid held high and out_ready tied high
    ba[0] = 16'h1234; bb[0] = 16'h4321; bc[0] = 1'b0;
    ba[1] = 16'hFFFF; bb[1] = 16'h0000; bc[1] = 1'b1;
    ba[2] = 16'hA5A5; bb[2] = 16'h5A5A; bc[2] = 1'b1;
    k = 0; r = 0; cyc = 0;
    in_valid = 1'b1; a = ba[0]; b = bb[0]; c_in = bc[0];
    while (r < 3 && cyc < 40) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        ref_v = {1'b0, ba[r]} + {1'b0, bb[r]} + 17'(bc[r]);
        chk($sformatf("b2b%0d_sum", r), sum, ref_v[15:0]);
        chk($sformatf("b2b%0d_cout", r), c_out, ref_v[16]);
        t[r] = cyc;
        r++;
      end
      tick(); cyc++;
      if (acc) begin
        k++;
        if (k < 3) begin a = ba[k]; b = bb[k]; c_in = bc[k]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", r, 3);
    if (r == 3) begin
      chk("b2b_gap01", t[1] - t[0], 6);
      chk("b2b_gap12", t[2] - t[1], 6);
    end
    repeat (2) tick();

    // Random regression with idle gaps and output backpressure
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      do_op(ra, rb, rc, ref_v[15:0], ref_v[16],
            (ra[15] == rb[15]) && (ref_v[15] != ra[15]),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
